// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared definitions for the image sweep master: default memory geometry and
// the sweep FSM state encoding.
//
// Contents:
//   IMG_ADDR_W     default memory word-address width
//   IMG_DATA_W     default memory word width (8 bytes per word)
//   IMG_LAST_ADDR  default highest valid memory word address
//   sweep_state_t  FSM states of the sweep master
// ---------------------------------------------------------------------------
package image_pkg;

    localparam int IMG_ADDR_W    = 16;
    localparam int IMG_DATA_W    = 64;
    localparam int IMG_LAST_ADDR = 15450;

    // One word costs a READ and a WRITE cycle; SAVE/WAIT_SAVE hand the image
    // to the memory and FINISH is the single cycle in which done/error show.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        SAVE,
        WAIT_SAVE,
        FINISH
    } sweep_state_t;

endpackage

// File: rtl/sat_add8.sv
// ---------------------------------------------------------------------------
// sat_add8
// Adds two unsigned bytes and clamps the result at 255.
//
// Ports:
//   a    in   8  pixel byte
//   b    in   8  brightness offset
//   sum  out  8  min(255, a + b)
// ---------------------------------------------------------------------------
module sat_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic [8:0] wide;

    // The ninth bit is the carry out; any carry means the true sum exceeds 255.
    assign wide = {1'b0, a} + {1'b0, b};
    assign sum  = wide[8] ? 8'hFF : wide[7:0];

endmodule

// File: rtl/image_sweep_master.sv
// ---------------------------------------------------------------------------
// image_sweep_master
// Walks a contiguous range of image memory words, brightens every byte with a
// saturating add, writes each word back in place, then asks the memory to save
// the image and waits (bounded) for its acknowledge.
//
// Parameters:
//   ADDR_W        memory word-address width
//   DATA_W        memory word width, a multiple of 8
//   LAST_ADDR     highest valid memory word address
//   SAVE_TIMEOUT  cycles to wait for doneSaving before flagging an error
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   start        in   1       one-cycle sweep request (ignored while busy)
//   baseAddr     in   ADDR_W  first word of the sweep
//   wordCount    in   ADDR_W  number of words to process
//   brightness   in   8       value added to every byte
//   address      out  ADDR_W  memory word address
//   readData     in   DATA_W  combinational read data for address
//   writeData    out  DATA_W  memory write data
//   writeEnable  out  1       memory write strobe
//   save         out  1       one-cycle image-save request
//   doneSaving   in   1       save-complete acknowledge (level)
//   busy         out  1       sweep in progress
//   done         out  1       one-cycle pulse on successful completion
//   error        out  1       range violation or save timeout, sticky
// ---------------------------------------------------------------------------
module image_sweep_master
    import image_pkg::*;
#(
    parameter int ADDR_W       = IMG_ADDR_W,
    parameter int DATA_W       = IMG_DATA_W,
    parameter int LAST_ADDR    = IMG_LAST_ADDR,
    parameter int SAVE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] wordCount,
    input  logic [7:0]        brightness,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic              save,
    input  logic              doneSaving,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int LANES   = DATA_W / 8;
    localparam int TIMER_W = $clog2(SAVE_TIMEOUT + 1);

    localparam logic [ADDR_W:0]    LAST_ADDR_EXT = (ADDR_W + 1)'(LAST_ADDR);
    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(SAVE_TIMEOUT - 1);

    sweep_state_t      state;
    logic [ADDR_W-1:0] remaining;
    logic [7:0]        bright_reg;
    logic [DATA_W-1:0] captured_word;
    logic [DATA_W-1:0] transformed;
    logic [TIMER_W-1:0] save_timer;
    logic [ADDR_W:0]   sweep_end;
    logic              out_of_range;

    // The last address touched is computed one bit wider than the address so
    // that a range running past the top of the address space cannot wrap back
    // into a small, apparently legal value.
    assign sweep_end    = {1'b0, baseAddr} + {1'b0, wordCount} - (ADDR_W + 1)'(1);
    assign out_of_range = (wordCount != '0) && (sweep_end > LAST_ADDR_EXT);

    // One saturating adder per byte lane; lanes never carry into each other.
    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        sat_add8 u_sat_add8 (
            .a   (captured_word[8*lane +: 8]),
            .b   (bright_reg),
            .sum (transformed[8*lane +: 8])
        );
    end

    // Write data only leaves the block during WRITE, so the bus reads zero
    // after reset and whenever no write is being issued.
    assign writeData = (state == WRITE) ? transformed : '0;

    // Sweep sequencer. The strobes writeEnable, save and done default low
    // every cycle and are raised only on the edge entering the state that
    // owns them, which makes each of them exactly one cycle wide. address
    // doubles as the word pointer, so READ and WRITE see the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            address       <= '0;
            remaining     <= '0;
            bright_reg    <= '0;
            captured_word <= '0;
            save_timer    <= '0;
            writeEnable   <= 1'b0;
            save          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            writeEnable <= 1'b0;
            save        <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        address    <= baseAddr;
                        remaining  <= wordCount;
                        bright_reg <= brightness;
                        if (out_of_range) begin
                            error <= 1'b1;
                            state <= FINISH;
                        end else if (wordCount == '0) begin
                            save  <= 1'b1;
                            state <= SAVE;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    captured_word <= readData;
                    writeEnable   <= 1'b1;
                    state         <= WRITE;
                end

                WRITE: begin
                    address   <= address + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                    if (remaining == ADDR_W'(1)) begin
                        save  <= 1'b1;
                        state <= SAVE;
                    end else begin
                        state <= READ;
                    end
                end

                SAVE: begin
                    save_timer <= '0;
                    state      <= WAIT_SAVE;
                end

                // The acknowledge is checked before the timeout so that an
                // acknowledge arriving in the last allowed cycle still counts.
                WAIT_SAVE: begin
                    if (doneSaving) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (save_timer == TIMER_LAST) begin
                        error <= 1'b1;
                        state <= FINISH;
                    end else begin
                        save_timer <= save_timer + TIMER_W'(1);
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_sweep_master.sv
// ---------------------------------------------------------------------------
// tb_image_sweep_master
// Directed scoreboard bench for image_sweep_master. Each sweep pushes its
// hand-computed writes, save pulse and finish status into a queue; a monitor
// on the falling clock edge pops and compares whenever the DUT writes, saves
// or drops busy.
// ---------------------------------------------------------------------------
module tb_image_sweep_master;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 64;
    localparam int LAST_ADDR    = 15450;
    localparam int SAVE_TIMEOUT = 1024;

    localparam int EV_WRITE  = 0;
    localparam int EV_SAVE   = 1;
    localparam int EV_FINISH = 2;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                idx;
        logic              done;
        logic              err;
        int                busyCycles;
        int                gap;
    } expect_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] baseAddr;
    logic [ADDR_W-1:0] wordCount;
    logic [7:0]        brightness;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] writeData;
    logic              writeEnable;
    logic              save;
    logic              doneSaving;
    logic              busy;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;
    expect_t expQ[$];

    always #5 clk = ~clk;

    image_sweep_master #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LAST_ADDR    (LAST_ADDR),
        .SAVE_TIMEOUT (SAVE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .baseAddr    (baseAddr),
        .wordCount   (wordCount),
        .brightness  (brightness),
        .address     (address),
        .readData    (readData),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .save        (save),
        .doneSaving  (doneSaving),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Memory model: combinational read, write on the clock edge. The save
    // acknowledge rises ackDelay cycles after the save pulse and stays high;
    // ackDelay of -1 means the memory never acknowledges.
    logic [DATA_W-1:0] mem [0:65535];
    logic              pokeEn = 1'b0;
    logic [ADDR_W-1:0] pokeAddr = '0;
    logic [DATA_W-1:0] pokeData = '0;
    int                ackDelay = 0;
    int                ackCount = -1;

    assign readData   = mem[address];
    assign doneSaving = (ackCount == 0);

    always @(posedge clk) begin
        if (pokeEn) mem[pokeAddr] <= pokeData;
        if (writeEnable) mem[address] <= writeData;
        if (save) ackCount <= ackDelay;
        else if (ackCount > 0) ackCount <= ackCount - 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        checks++;
        failures++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    function automatic void expectWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        expect_t e;
        e = '{kind: EV_WRITE, addr: addr, data: data, idx: 0, done: 1'b0, err: 1'b0, busyCycles: 0, gap: -1};
        expQ.push_back(e);
    endfunction

    function automatic void expectSave(input int idx);
        expect_t e;
        e = '{kind: EV_SAVE, addr: '0, data: '0, idx: idx, done: 1'b0, err: 1'b0, busyCycles: 0, gap: -1};
        expQ.push_back(e);
    endfunction

    function automatic void expectFinish(input logic d, input logic er, input int cycles, input int gap);
        expect_t e;
        e = '{kind: EV_FINISH, addr: '0, data: '0, idx: 0, done: d, err: er, busyCycles: cycles, gap: gap};
        expQ.push_back(e);
    endfunction

    // Monitor. busyIdx numbers the cycles of the current sweep from 1; the
    // finish check fires on the first sample after busy drops. gap is the
    // number of cycles strictly between the save pulse and error rising.
    initial begin
        int      busyIdx;
        int      saveIdx;
        int      errIdx;
        logic    prevBusy;
        logic    doneSeen;
        expect_t e;
        busyIdx  = 0;
        saveIdx  = -1;
        errIdx   = -1;
        prevBusy = 1'b0;
        doneSeen = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busyIdx++;
            if (writeEnable) begin
                if (expQ.size() == 0) failNow("unexpected_write", $sformatf("addr 0x%0h data 0x%0h", address, writeData));
                else begin
                    e = expQ.pop_front();
                    checkOutput("write_kind", 64'(e.kind), 64'(EV_WRITE));
                    checkOutput("write_addr", 64'(address), 64'(e.addr));
                    checkOutput("write_data", writeData, e.data);
                end
            end
            if (save) begin
                saveIdx = busyIdx;
                if (expQ.size() == 0) failNow("unexpected_save", $sformatf("at sweep cycle %0d", busyIdx));
                else begin
                    e = expQ.pop_front();
                    checkOutput("save_kind", 64'(e.kind), 64'(EV_SAVE));
                    checkOutput("save_cycle", 64'(busyIdx), 64'(e.idx));
                end
            end
            if (done) doneSeen = 1'b1;
            if (error && busy && errIdx < 0) errIdx = busyIdx;
            if (rst) begin
                busyIdx  = 0;
                saveIdx  = -1;
                errIdx   = -1;
                doneSeen = 1'b0;
                prevBusy = 1'b0;
            end else begin
                if (prevBusy && !busy) begin
                    if (expQ.size() == 0) failNow("unexpected_finish", $sformatf("after %0d busy cycles", busyIdx));
                    else begin
                        e = expQ.pop_front();
                        checkOutput("finish_kind", 64'(e.kind), 64'(EV_FINISH));
                        checkOutput("done_pulse", 64'(doneSeen), 64'(e.done));
                        checkOutput("error_flag", 64'(error), 64'(e.err));
                        checkOutput("busy_cycles", 64'(busyIdx), 64'(e.busyCycles));
                        if (e.gap >= 0) checkOutput("save_to_error", 64'(errIdx - saveIdx - 1), 64'(e.gap));
                    end
                    busyIdx  = 0;
                    saveIdx  = -1;
                    errIdx   = -1;
                    doneSeen = 1'b0;
                end
                prevBusy = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pokeWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pokeAddr = addr;
        pokeData = data;
        pokeEn   = 1'b1;
        tick();
        pokeEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count,
                                 input logic [7:0] bright, input int delay);
        ackDelay   = delay;
        baseAddr   = base;
        wordCount  = count;
        brightness = bright;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) failNow(name, $sformatf("busy still high after %0d cycles", budget));
        tick();
        checkOutput({name, "_drained"}, 64'(expQ.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        baseAddr   = '0;
        wordCount  = '0;
        brightness = '0;
        tick();
        tick();

        checkOutput("reset_address", 64'(address), 64'(0));
        checkOutput("reset_writeData", writeData, 64'(0));
        checkOutput("reset_writeEnable", 64'(writeEnable), 64'(0));
        checkOutput("reset_save", 64'(save), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_error", 64'(error), 64'(0));
        rst = 1'b0;

        pokeWord(16'd10,    64'h0010_F0FF_0102_0304);
        pokeWord(16'd11,    64'h0123_4567_89AB_CDEF);
        pokeWord(16'd12,    64'hF5F0_EF00_00FF_FF80);
        pokeWord(16'd15449, 64'h8000_0000_0000_0000);
        pokeWord(16'd15450, 64'h7F80_FE01_0203_0405);
        pokeWord(16'd50,    64'h0000_0000_0000_00FF);
        pokeWord(16'd20,    64'h0000_0000_0000_0000);
        pokeWord(16'd21,    64'hFAFB_FCFD_FEFF_0001);
        pokeWord(16'd30,    64'hAAAA_AAAA_AAAA_AAAA);
        pokeWord(16'd40,    64'h0102_0304_0506_0708);
        pokeWord(16'd41,    64'hFFFE_FDFC_0000_0000);
        pokeWord(16'd42,    64'h1111_1111_1111_1111);
        pokeWord(16'd43,    64'h2222_2222_2222_2222);

        $display("[TB] three-word sweep at 10, brightness 0x10");
        expectWrite(16'd10, 64'h1020_FFFF_1112_1314);
        expectWrite(16'd11, 64'h1133_5577_99BB_DDFF);
        expectWrite(16'd12, 64'hFFFF_FF10_10FF_FF90);
        expectSave(7);
        expectFinish(1'b1, 1'b0, 12, -1);
        applyStimulus(16'd10, 16'd3, 8'h10, 3);
        waitIdle("sweep3", 200);

        $display("[TB] range past LAST_ADDR aborts");
        expectFinish(1'b0, 1'b1, 1, -1);
        applyStimulus(16'd15450, 16'd2, 8'h10, 0);
        waitIdle("range_abort", 20);
        checkOutput("error_sticky", 64'(error), 64'(1));

        $display("[TB] range ending exactly at LAST_ADDR");
        expectWrite(16'd15449, 64'hFF7F_7F7F_7F7F_7F7F);
        expectWrite(16'd15450, 64'hFEFF_FF80_8182_8384);
        expectSave(5);
        expectFinish(1'b1, 1'b0, 7, -1);
        applyStimulus(16'd15449, 16'd2, 8'h7F, 0);
        waitIdle("range_edge", 100);

        $display("[TB] range wrapping the address space aborts");
        expectFinish(1'b0, 1'b1, 1, -1);
        applyStimulus(16'hFFFF, 16'd2, 8'h01, 0);
        waitIdle("wrap_abort", 20);

        $display("[TB] zero-word sweep saves immediately");
        expectSave(1);
        expectFinish(1'b1, 1'b0, 3, -1);
        applyStimulus(16'd100, 16'd0, 8'h10, 0);
        waitIdle("zero_words", 50);

        $display("[TB] save acknowledge never arrives");
        expectWrite(16'd50, 64'h0101_0101_0101_01FF);
        expectSave(3);
        expectFinish(1'b0, 1'b1, SAVE_TIMEOUT + 4, SAVE_TIMEOUT);
        applyStimulus(16'd50, 16'd1, 8'h01, -1);
        waitIdle("save_timeout", SAVE_TIMEOUT + 100);

        $display("[TB] start held while busy, through FINISH");
        expectWrite(16'd20, 64'h0505_0505_0505_0505);
        expectWrite(16'd21, 64'hFFFF_FFFF_FFFF_0506);
        expectSave(5);
        expectFinish(1'b1, 1'b0, 8, -1);
        applyStimulus(16'd20, 16'd2, 8'h05, 1);
        baseAddr  = 16'd30;
        wordCount = 16'd5;
        start     = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) failNow("busy_start_done", "done never seen");
        tick();
        start = 1'b0;
        checkOutput("busy_start_ignored", 64'(busy), 64'(0));
        tick();
        checkOutput("busy_start_still_idle", 64'(busy), 64'(0));
        waitIdle("busy_start", 10);

        $display("[TB] reset during the second WRITE of a four-word sweep");
        expectWrite(16'd40, 64'h0203_0405_0607_0809);
        expectWrite(16'd41, 64'hFFFF_FEFD_0101_0101);
        applyStimulus(16'd40, 16'd4, 8'h01, 0);
        tick();
        tick();
        tick();
        checkOutput("second_write_strobe", 64'(writeEnable), 64'(1));
        rst = 1'b1;
        tick();
        checkOutput("midreset_address", 64'(address), 64'(0));
        checkOutput("midreset_writeData", writeData, 64'(0));
        checkOutput("midreset_outputs", 64'({writeEnable, save, busy, done, error}), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        checkOutput("midreset_idle", 64'(busy), 64'(0));
        checkOutput("midreset_drained", 64'(expQ.size()), 64'(0));

        checkOutput("mem10", mem[10], 64'h1020_FFFF_1112_1314);
        checkOutput("mem11", mem[11], 64'h1133_5577_99BB_DDFF);
        checkOutput("mem12", mem[12], 64'hFFFF_FF10_10FF_FF90);
        checkOutput("mem15449", mem[15449], 64'hFF7F_7F7F_7F7F_7F7F);
        checkOutput("mem15450", mem[15450], 64'hFEFF_FF80_8182_8384);
        checkOutput("mem50", mem[50], 64'h0101_0101_0101_01FF);
        checkOutput("mem20", mem[20], 64'h0505_0505_0505_0505);
        checkOutput("mem21", mem[21], 64'hFFFF_FFFF_FFFF_0506);
        checkOutput("mem30_untouched", mem[30], 64'hAAAA_AAAA_AAAA_AAAA);
        checkOutput("mem40", mem[40], 64'h0203_0405_0607_0809);
        checkOutput("mem41", mem[41], 64'hFFFF_FEFD_0101_0101);
        checkOutput("mem42_untouched", mem[42], 64'h1111_1111_1111_1111);
        checkOutput("mem43_untouched", mem[43], 64'h2222_2222_2222_2222);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_sweep_master.md
IMAGE_SWEEP_MASTER -- requirements
Module: image_sweep_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory word width (8 bytes).
REQ-003 SHALL have parameter LAST_ADDR, default 15450, highest valid memory word address.
REQ-004 SHALL have parameter SAVE_TIMEOUT, default 1024, maximum number of cycles to wait for doneSaving.
REQ-005 SHALL have port clk, input, 1, sole clock; rising edge active.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a sweep.
REQ-008 SHALL have port baseAddr, input, ADDR_W, first word address of the sweep.
REQ-009 SHALL have port wordCount, input, ADDR_W, number of words to process.
REQ-010 SHALL have port brightness, input, 8, per-byte saturating add value.
REQ-011 SHALL have port address, output, ADDR_W, memory word address.
REQ-012 SHALL have port readData, input, DATA_W, combinational memory read data for address.
REQ-013 SHALL have port writeData, output, DATA_W, memory write data.
REQ-014 SHALL have port writeEnable, output, 1, memory write strobe.
REQ-015 SHALL have port save, output, 1, one-cycle image-save request to memory.
REQ-016 SHALL have port doneSaving, input, 1, memory save-complete acknowledge (level).
REQ-017 SHALL have port busy, output, 1, high from sweep acceptance until return to IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-019 SHALL have port error, output, 1, sticky until next accepted start; high on range violation or save timeout.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, SAVE, WAIT_SAVE, FINISH.
REQ-021 SHALL, in IDLE, accept start only when busy=0; baseAddr, wordCount and brightness latched on acceptance; error cleared.
REQ-022 SHALL, on acceptance, go to ERROR-abort (FINISH, error=1, done=0) if wordCount>0 and baseAddr+wordCount-1 > LAST_ADDR, computed at ADDR_W+1 bits with no wrap.
REQ-023 SHALL go directly to SAVE on acceptance when wordCount=0.
REQ-024 SHALL, in READ, drive address=current pointer, writeEnable=0, and capture readData into a DATA_W register at the clock edge ending READ.
REQ-025 SHALL, in WRITE, drive the same address, writeEnable=1 for exactly one cycle, writeData=transformed captured word.
REQ-026 SHALL transform each byte i as min(255, byte_i + brightness), computed at 9 bits and then saturated; bytes are independent.
REQ-027 SHALL use exactly 2 cycles per word (READ, WRITE); pointer increments after WRITE; remaining count decrements after WRITE.
REQ-028 SHALL go from WRITE to READ while words remain, else to SAVE.
REQ-029 SHALL assert save for exactly one cycle in SAVE, then enter WAIT_SAVE.
REQ-030 SHALL, in WAIT_SAVE, go to FINISH with done=1 when doneSaving=1; set error=1 and go to FINISH with done=0 if SAVE_TIMEOUT cycles elapse first.
REQ-031 SHALL, in FINISH, hold busy=1 for one cycle, pulse done if successful, then return to IDLE.
REQ-032 SHALL ignore start while busy=1, including start asserted in the FINISH cycle.
REQ-033 SHALL keep writeEnable=0 and save=0 in all states other than WRITE and SAVE respectively.
REQ-034 SHALL produce an N-word sweep that completes, from the start edge, in 2N+2+(save latency) cycles.

Reset
REQ-035 SHALL, with rst=1 at a clock edge, enter IDLE and set address=0, writeData=0, writeEnable=0, save=0, busy=0, done=0, error=0, and clear counters.
REQ-036 SHALL, on reset mid-sweep, abandon the sweep with no further write issued; rst has priority over start.

Structure
REQ-037 SHALL place the FSM state enum and the DATA_W/ADDR_W/LAST_ADDR defaults in shared package image_pkg.
REQ-038 SHALL implement the per-byte saturating adder as sub-module sat_add8, instantiated DATA_W/8 times.

Verification
REQ-039 SHALL cover: baseAddr=10, wordCount=3, brightness=0x10, mem[10]=0x00_10_F0_FF_01_02_03_04 -> mem[10]=0x10_20_FF_FF_11_12_13_14; 3 writes; one save pulse; done after doneSaving.
REQ-040 SHALL cover: wordCount=0 -> no writeEnable pulse, save at cycle 1, done after doneSaving.
REQ-041 SHALL cover: baseAddr=15450, wordCount=2 -> error=1, no writes, no save, done=0.
REQ-042 SHALL cover: doneSaving held 0 -> error=1 exactly SAVE_TIMEOUT cycles after save, done=0, busy falls.
REQ-043 SHALL cover: rst asserted during the second WRITE of a 4-word sweep -> words 3-4 unchanged, all outputs 0 the next cycle.
REQ-044 SHALL cover: start pulsed while busy -> ignored; the sweep completes unchanged.
